// File: rtl/axi_addr_arbiter_if.sv
// axi_addr_arbiter_if: bundles the requester-side and memory-side address
// channel signals of axi_addr_arbiter.
// The master modport is the arbiter's own view: it accepts requests and drives
// the shared channel.
// The slave modport is the environment's view: it covers the requesters and
// the downstream interconnect.
interface axi_addr_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int PORT_SEL_WIDTH = 1,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 8
);

  logic [NUM_PORTS*ID_WIDTH-1:0]       s_axid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]     s_axaddr;
  logic [NUM_PORTS*8-1:0]              s_axlen;
  logic [NUM_PORTS*3-1:0]              s_axsize;
  logic [NUM_PORTS*2-1:0]              s_axburst;
  logic [NUM_PORTS-1:0]                s_axlock;
  logic [NUM_PORTS*4-1:0]              s_axcache;
  logic [NUM_PORTS*3-1:0]              s_axprot;
  logic [NUM_PORTS-1:0]                s_axvalid;
  logic [NUM_PORTS-1:0]                s_axready;

  logic [ID_WIDTH+PORT_SEL_WIDTH-1:0]  m_axid;
  logic [ADDR_WIDTH-1:0]               m_axaddr;
  logic [7:0]                          m_axlen;
  logic [2:0]                          m_axsize;
  logic [1:0]                          m_axburst;
  logic                                m_axlock;
  logic [3:0]                          m_axcache;
  logic [2:0]                          m_axprot;
  logic                                m_axvalid;
  logic                                m_axready;

  modport master (
    input  s_axid, s_axaddr, s_axlen, s_axsize, s_axburst, s_axlock,
           s_axcache, s_axprot, s_axvalid,
    output s_axready,
    output m_axid, m_axaddr, m_axlen, m_axsize, m_axburst, m_axlock,
           m_axcache, m_axprot, m_axvalid,
    input  m_axready
  );

  modport slave (
    output s_axid, s_axaddr, s_axlen, s_axsize, s_axburst, s_axlock,
           s_axcache, s_axprot, s_axvalid,
    input  s_axready,
    input  m_axid, m_axaddr, m_axlen, m_axsize, m_axburst, m_axlock,
           m_axcache, m_axprot, m_axvalid,
    output m_axready
  );

endinterface

// File: rtl/axi_addr_arbiter.sv
// axi_addr_arbiter: shares one AXI4 AR/AW channel between NUM_PORTS burst
// requesters.
// Whole bursts are granted in round-robin order, through one registered
// output stage.
// The winning port index is prepended to the outgoing ID, so that responses
// can be steered back to the right requester.
// Optional feature, enabled by defining AXI_ADDR_ARBITER_GRANT_HOLD_EN:
// - a port may win up to MAX_HOLD consecutive bursts before the pointer moves
//   on, which keeps streaming bursts together for DRAM page locality.
module axi_addr_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int PORT_SEL_WIDTH = 1,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int MAX_HOLD       = 4
) (
  input  logic              aclk,
  input  logic              resetn,
  axi_addr_arbiter_if.master bus
);

  localparam int SW1 = PORT_SEL_WIDTH + 1;

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : gBadPorts
    $error("axi_addr_arbiter: NUM_PORTS must be in 2..8");
  end
  if (PORT_SEL_WIDTH < $clog2(NUM_PORTS)) begin : gBadSel
    $error("axi_addr_arbiter: PORT_SEL_WIDTH too small for NUM_PORTS");
  end
  if (MAX_HOLD < 1) begin : gBadHold
    $error("axi_addr_arbiter: MAX_HOLD must be at least 1");
  end

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                    state;
  logic [PORT_SEL_WIDTH-1:0] rrPtr;
  logic [PORT_SEL_WIDTH-1:0] sel;
  logic [PORT_SEL_WIDTH-1:0] selNext;
  logic                      anyValid;
  logic [2*NUM_PORTS-1:0]    validTwice;
  logic [NUM_PORTS-1:0]      rotValid;
  logic [SW1-1:0]            sum;

  logic [ID_WIDTH-1:0]       selId;
  logic [ADDR_WIDTH-1:0]     selAddr;
  logic [7:0]                selLen;
  logic [2:0]                selSize;
  logic [1:0]                selBurst;
  logic                      selLock;
  logic [3:0]                selCache;
  logic [2:0]                selProt;

`ifdef AXI_ADDR_ARBITER_GRANT_HOLD_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] holdCnt;
`endif

  // Round-robin pick: rotate valids so rrPtr lands on bit 0, then take the first set bit
  always_comb begin
    validTwice = {bus.s_axvalid, bus.s_axvalid};
    rotValid   = NUM_PORTS'(validTwice >> rrPtr);
    sel        = '0;
    anyValid   = 1'b0;
    sum        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!anyValid && rotValid[k]) begin
        anyValid = 1'b1;
        sum      = SW1'(rrPtr) + SW1'(k);
        if (sum >= SW1'(NUM_PORTS)) begin
          sum = sum - SW1'(NUM_PORTS);
        end
        sel = sum[PORT_SEL_WIDTH-1:0];
      end
    end
    selNext = ((SW1'(sel) + SW1'(1)) == SW1'(NUM_PORTS)) ? '0 : sel + 1'b1;
  end

  // Mux the winner's request fields, and raise its ready only when the output stage is empty
  always_comb begin
    selId         = '0;
    selAddr       = '0;
    selLen        = '0;
    selSize       = '0;
    selBurst      = '0;
    selLock       = 1'b0;
    selCache      = '0;
    selProt       = '0;
    bus.s_axready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == PORT_SEL_WIDTH'(i)) begin
        selId    = bus.s_axid[i*ID_WIDTH +: ID_WIDTH];
        selAddr  = bus.s_axaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selLen   = bus.s_axlen[i*8 +: 8];
        selSize  = bus.s_axsize[i*3 +: 3];
        selBurst = bus.s_axburst[i*2 +: 2];
        selLock  = bus.s_axlock[i];
        selCache = bus.s_axcache[i*4 +: 4];
        selProt  = bus.s_axprot[i*3 +: 3];
        bus.s_axready[i] = resetn && (state == EMPTY) && anyValid;
      end
    end
  end

  // Output stage FSM: capture a grant when EMPTY, release it on the downstream handshake
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state         <= EMPTY;
      rrPtr         <= '0;
      bus.m_axvalid <= 1'b0;
      bus.m_axid    <= '0;
      bus.m_axaddr  <= '0;
      bus.m_axlen   <= '0;
      bus.m_axsize  <= '0;
      bus.m_axburst <= '0;
      bus.m_axlock  <= 1'b0;
      bus.m_axcache <= '0;
      bus.m_axprot  <= '0;
`ifdef AXI_ADDR_ARBITER_GRANT_HOLD_EN
      holdCnt       <= '0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (anyValid) begin
            state         <= FULL;
            bus.m_axvalid <= 1'b1;
            bus.m_axid    <= {sel, selId};
            bus.m_axaddr  <= selAddr;
            bus.m_axlen   <= selLen;
            bus.m_axsize  <= selSize;
            bus.m_axburst <= selBurst;
            bus.m_axlock  <= selLock;
            bus.m_axcache <= selCache;
            bus.m_axprot  <= selProt;
`ifdef AXI_ADDR_ARBITER_GRANT_HOLD_EN
            if (sel == rrPtr && holdCnt < HOLD_W'(MAX_HOLD - 1)) begin
              holdCnt <= holdCnt + 1'b1;
            end else begin
              rrPtr   <= selNext;
              holdCnt <= '0;
            end
`else
            rrPtr <= selNext;
`endif
          end
        end
        FULL: begin
          if (bus.m_axready) begin
            state         <= EMPTY;
            bus.m_axvalid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_addr_arbiter.sv
// tb_axi_addr_arbiter: directed self-checking bench for axi_addr_arbiter.
// busA drives a 2-port arbiter; busB drives a 3-port arbiter.
// The expected grant order follows AXI_ADDR_ARBITER_GRANT_HOLD_EN when that
// macro is defined.
module tb_axi_addr_arbiter;

  logic aclk;
  logic resetn;
  int   checkCount;
  int   errorCount;
  int   expSeq[8];
  int   expPort;

  axi_addr_arbiter_if #(.NUM_PORTS(2), .PORT_SEL_WIDTH(1), .ADDR_WIDTH(32), .ID_WIDTH(8)) busA();
  axi_addr_arbiter_if #(.NUM_PORTS(3), .PORT_SEL_WIDTH(2), .ADDR_WIDTH(32), .ID_WIDTH(8)) busB();

  axi_addr_arbiter #(.NUM_PORTS(2), .PORT_SEL_WIDTH(1), .ADDR_WIDTH(32), .ID_WIDTH(8), .MAX_HOLD(4)) dutA (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (busA)
  );

  axi_addr_arbiter #(.NUM_PORTS(3), .PORT_SEL_WIDTH(2), .ADDR_WIDTH(32), .ID_WIDTH(8), .MAX_HOLD(4)) dutB (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (busB)
  );

  // Free-running 10-unit clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic [7:0] id,
                               input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    if (port == 0) begin
      busA.s_axvalid[0]   = valid;
      busA.s_axid[7:0]    = id;
      busA.s_axaddr[31:0] = addr;
      busA.s_axlen[7:0]   = len;
      busA.s_axsize[2:0]  = size;
    end else begin
      busA.s_axvalid[1]    = valid;
      busA.s_axid[15:8]    = id;
      busA.s_axaddr[63:32] = addr;
      busA.s_axlen[15:8]   = len;
      busA.s_axsize[5:3]   = size;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
`ifdef AXI_ADDR_ARBITER_GRANT_HOLD_EN
    expSeq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    expSeq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    resetn = 1'b0;

    busA.s_axid = '0; busA.s_axaddr = '0; busA.s_axlen = '0; busA.s_axsize = '0;
    busA.s_axburst = 4'b0110; busA.s_axlock = 2'b10; busA.s_axcache = 8'h3F; busA.s_axprot = 6'b010_101;
    busA.s_axvalid = '0; busA.m_axready = 1'b1;
    applyStimulus(0, 1'b1, 8'hA0, 32'h0000_0100, 8'd3, 3'd2);
    applyStimulus(1, 1'b1, 8'hB1, 32'h0000_0200, 8'd7, 3'd2);

    busB.s_axid = {8'hC2, 8'hC1, 8'hC0}; busB.s_axaddr = '0; busB.s_axlen = '0; busB.s_axsize = '0;
    busB.s_axburst = '0; busB.s_axlock = '0; busB.s_axcache = '0; busB.s_axprot = '0;
    busB.s_axvalid = '0; busB.m_axready = 1'b1;

    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      checkOutput("rst_mvalid", 64'(busA.m_axvalid), 64'd0);
      checkOutput("rst_ready", 64'(busA.s_axready), 64'd0);
    end
    resetn = 1'b1;
    #1;

    for (int g = 0; g < 8; g++) begin
      expPort = expSeq[g];
      checkOutput("rr_ready", 64'(busA.s_axready), 64'(1 << expPort));
      tick(); #1;
      checkOutput("rr_mvalid_hi", 64'(busA.m_axvalid), 64'd1);
      checkOutput("rr_mid", 64'(busA.m_axid), (expPort == 1) ? 64'h1B1 : 64'h0A0);
      checkOutput("rr_ready_full", 64'(busA.s_axready), 64'd0);
      tick(); #1;
      checkOutput("rr_mvalid_lo", 64'(busA.m_axvalid), 64'd0);
    end

    busA.s_axvalid = 2'b00;
    applyStimulus(1, 1'b1, 8'h5C, 32'h0000_1000, 8'd15, 3'd3);
    #1;
    checkOutput("p1_ready", 64'(busA.s_axready), 64'b10);
    tick(); #1;
    checkOutput("p1_mvalid", 64'(busA.m_axvalid), 64'd1);
    checkOutput("p1_addr", 64'(busA.m_axaddr), 64'h1000);
    checkOutput("p1_len", 64'(busA.m_axlen), 64'd15);
    checkOutput("p1_size", 64'(busA.m_axsize), 64'd3);
    checkOutput("p1_id", 64'(busA.m_axid), 64'h15C);
    checkOutput("p1_burst", 64'(busA.m_axburst), 64'd1);
    checkOutput("p1_lock", 64'(busA.m_axlock), 64'd1);
    checkOutput("p1_cache", 64'(busA.m_axcache), 64'h3);
    checkOutput("p1_prot", 64'(busA.m_axprot), 64'h2);

    busA.m_axready = 1'b0;
    busA.s_axvalid = 2'b11;
    applyStimulus(1, 1'b1, 8'h77, 32'h0000_2000, 8'd7, 3'd2);
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      checkOutput("hold_mvalid", 64'(busA.m_axvalid), 64'd1);
      checkOutput("hold_addr", 64'(busA.m_axaddr), 64'h1000);
      checkOutput("hold_id", 64'(busA.m_axid), 64'h15C);
      checkOutput("hold_ready", 64'(busA.s_axready), 64'd0);
    end
    busA.m_axready = 1'b1;
    tick(); #1;
    checkOutput("drain_mvalid", 64'(busA.m_axvalid), 64'd0);
    checkOutput("wrap_ready", 64'(busA.s_axready), 64'b01);

    busA.s_axvalid = 2'b00;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      checkOutput("idle_mvalid", 64'(busA.m_axvalid), 64'd0);
      checkOutput("idle_ready", 64'(busA.s_axready), 64'd0);
    end
    busA.s_axvalid = 2'b11;
    #1;
    checkOutput("idle_ptr_ready", 64'(busA.s_axready), 64'b01);

    busA.m_axready = 1'b0;
    tick(); #1;
    checkOutput("rstfull_pre", 64'(busA.m_axvalid), 64'd1);
    resetn = 1'b0;
    tick(); #1;
    checkOutput("rstfull_mvalid", 64'(busA.m_axvalid), 64'd0);
    checkOutput("rstfull_ready", 64'(busA.s_axready), 64'd0);
    busA.s_axvalid = 2'b00;
    busA.m_axready = 1'b1;
    resetn = 1'b1;

    busB.s_axvalid = 3'b001;
    #1;
    checkOutput("b_ready0", 64'(busB.s_axready), 64'b001);
    tick(); #1;
    checkOutput("b_id0", 64'(busB.m_axid), 64'h0C0);
    busB.s_axvalid = 3'b010;
    tick(); #1;
    checkOutput("b_ready1", 64'(busB.s_axready), 64'b010);
    tick(); #1;
    checkOutput("b_id1", 64'(busB.m_axid), 64'h1C1);
    busB.s_axvalid = 3'b011;
    tick(); #1;
    checkOutput("b_ptr2_ready", 64'(busB.s_axready), 64'b001);
    tick(); #1;
    checkOutput("b_ptr2_id", 64'(busB.m_axid), 64'h0C0);
    tick(); #1;
    checkOutput("b_ptr1_ready", 64'(busB.s_axready), 64'b010);
    tick(); #1;
    checkOutput("b_ptr1_id", 64'(busB.m_axid), 64'h1C1);
    busB.s_axvalid = 3'b000;

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
